multi_cycle_ctrl: RTL

// - Multi-cycle MIPS control FSM: drives ALUCtr/ALU operand selects into the ALU and consumes the ALU's Zero flag.
// - Also sequences PC, instruction register, register-file and memory enables, one instruction phase per state.
// - Sits between the instruction register (OpCode/Funct fields) and the shared datapath; stalls on memory via MemReady.

---
 rtl/multi_cycle_ctrl_pkg.sv | 50 +++++
 rtl/multi_cycle_ctrl_if.sv | 38 +++
 rtl/multi_cycle_ctrl_alu_ctr_decode.sv | 25 ++
 rtl/multi_cycle_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, ALU and datapath:
// opcodes, R-type function codes, ALU control words, mux selects and states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXR     = 4'd6,
        S_WBR     = 4'd7,
        S_EXI     = 4'd8,
        S_WBI     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// enables, strobes and mux selects out. master is the controller side.
interface multi_cycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [3:0] ALUCtr;
    logic [1:0] PCSource;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  OpCode, Funct, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUCtr, PCSource, Illegal, State
    );

    modport slave (
        output OpCode, Funct, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUCtr, PCSource, Illegal, State
    );

endinterface

// File: rtl/multi_cycle_ctrl_alu_ctr_decode.sv
// R-type function field to ALU control word, plus a flag telling whether
// the function code is one the datapath supports.
module alu_ctr_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctr,
    output logic       funct_ok
);

    // Pure lookup; unsupported codes fall back to add and clear funct_ok.
    always_comb begin
        alu_ctr  = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FN_ADD:  alu_ctr = ALU_ADD;
            FN_SUB:  alu_ctr = ALU_SUB;
            FN_AND:  alu_ctr = ALU_AND;
            FN_OR:   alu_ctr = ALU_OR;
            FN_SLT:  alu_ctr = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: one instruction phase per state, Moore
// output decode (PCWrite in BRANCH follows Zero, IRWrite/PCWrite in FETCH
// follow MemReady), strobes forced low while Reset is high.
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4 -> PC when memory completes
// DECODE  | classify opcode, branch target -> ALUOut
// MEMADDR | base + sign-extended offset
// MEMRD   | load data read, held until MemReady
// MEMWB   | MDR -> rt
// MEMWR   | store data write, held until MemReady
// EXR     | R-type ALU operation
// WBR     | ALUOut -> rd
// EXI     | immediate ALU operation
// WBI     | ALUOut -> rt
// BRANCH  | beq compare, PC <- ALUOut when Zero
// JUMP    | PC <- jump target
module multi_cycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    multi_cycle_ctrl_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    logic       illegal;
    logic [3:0] r_alu_ctr;
    logic       funct_ok;

    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_ctr;

    alu_ctr_decode u_alu_ctr_decode (
        .funct    (bus.Funct),
        .alu_ctr  (r_alu_ctr),
        .funct_ok (funct_ok)
    );

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state selection and illegal-instruction detection in DECODE.
    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:   if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.OpCode)
                    OP_RTYPE: begin
                        if (funct_ok) state_d = S_EXR;
                        else begin
                            state_d = S_FETCH;
                            illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW:               state_d = S_MEMADDR;
                    OP_BEQ:                     state_d = S_BRANCH;
                    OP_J:                       state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_EXI;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: state_d = (bus.OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.MemReady) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (bus.MemReady) state_d = S_FETCH;
            S_EXR:     state_d = S_WBR;
            S_WBR:     state_d = S_FETCH;
            S_EXI:     state_d = S_WBI;
            S_WBI:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Per-state control word; anything not set for a state stays 0.
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        ext_op     = 1'b0;
        alu_ctr    = ALU_AND;
        pc_source  = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ctr   = ALU_ADD;
                pc_source = PCSRC_ALU;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                ext_op    = 1'b1;
                alu_ctr   = ALU_ADD;
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
                alu_ctr   = ALU_ADD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_ctr   = r_alu_ctr;
            end
            S_WBR: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_EXI: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (bus.OpCode)
                    OP_ANDI: alu_ctr = ALU_AND;
                    OP_ORI:  alu_ctr = ALU_OR;
                    default: begin
                        ext_op  = 1'b1;
                        alu_ctr = ALU_ADD;
                    end
                endcase
            end
            S_WBI:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_ctr   = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = bus.Zero;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite  = pc_write  & ~Reset;
    assign bus.MemRead  = mem_read  & ~Reset;
    assign bus.MemWrite = mem_write & ~Reset;
    assign bus.IRWrite  = ir_write  & ~Reset;
    assign bus.RegWrite = reg_write & ~Reset;
    assign bus.Illegal  = illegal   & ~Reset;
    assign bus.IorD     = iord;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ExtOp    = ext_op;
    assign bus.ALUCtr   = alu_ctr;
    assign bus.PCSource = pc_source;
    assign bus.State    = state_q;

endmodule
